hilo_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core; sits in the execute/memory path.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, and services MTHI/MTLO writes.
- Drives hilo_mux_out (HI or LO per hilo_sel), which is latched by the memory-to-writeback pipeline register for MFHI/MFLO.
- Asserts busy so the hazard unit stalls younger HI/LO consumers.

---
 rtl/hilo_unit.sv | 163 ++++++++++++++++
 tb/tb_hilo_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. One shift-add or restoring shift-subtract step per cycle,
// followed by a single sign-correction cycle that commits HI/LO.
module hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   input  logic             hilo_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hilo_mux_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               neg_q;     // negate quotient / product
   logic               neg_r;     // negate remainder (sign of dividend)
   logic               div0;
   logic [WIDTH-1:0]   a_raw;     // original dividend for divide-by-zero result
   logic [WIDTH:0]     acc;       // product high half / partial remainder
   logic [WIDTH-1:0]   lsr;       // multiplier bits / dividend-quotient bits
   logic [WIDTH-1:0]   opnd;      // multiplicand / divisor magnitude

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_rs;
   logic [WIDTH:0]     acc_nx;
   logic [WIDTH-1:0]   lsr_nx;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;
   logic [2*WIDTH-1:0] prod_fix;

   // Two's-complement absolute value; unsigned ops pass through unchanged.
   // MIN_INT maps to itself, which is its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return (is_signed && sv < 0) ? WIDTH'(-sv) : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
      return neg ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   // One iteration of shift-add multiply or restoring divide on magnitudes.
   always_comb begin
      mul_sum = {1'b0, acc[WIDTH-1:0]} + (lsr[0] ? {1'b0, opnd} : '0);
      div_rs  = {acc[WIDTH-1:0], lsr[WIDTH-1]};
      acc_nx  = acc;
      lsr_nx  = lsr;
      if (is_div) begin
         if (div_rs >= {1'b0, opnd}) begin
            acc_nx = div_rs - {1'b0, opnd};
            lsr_nx = {lsr[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = div_rs;
            lsr_nx = {lsr[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx = {1'b0, mul_sum[WIDTH:1]};
         lsr_nx = {mul_sum[0], lsr[WIDTH-1:1]};
      end
   end

   // Sign correction and special cases applied when committing HI/LO.
   always_comb begin
      prod_fix = cond_neg_2w({acc[WIDTH-1:0], lsr}, neg_q);
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (div0) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            res_hi = cond_neg_w(acc[WIDTH-1:0], neg_r);
            res_lo = cond_neg_w(lsr, neg_q);
         end
      end
   end

   // Control FSM, iteration datapath and HI/LO register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         a_raw  <= '0;
         acc    <= '0;
         lsr    <= '0;
         opnd   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= CALC;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  is_div <= op[1];
                  neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= op[0] & a[WIDTH-1];
                  div0   <= (b == '0);
                  a_raw  <= a;
                  acc    <= '0;
                  lsr    <= op[1] ? magnitude(a, op[0]) : magnitude(b, op[0]);
                  opnd   <= op[1] ? magnitude(b, op[0]) : magnitude(a, op[0]);
               end else begin
                  if (we_hi) hi <= wd;
                  if (we_lo) lo <= wd;
               end
            end
            CALC: begin
               acc <= acc_nx;
               lsr <= lsr_nx;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign hilo_mux_out = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed testbench for hilo_unit: latency, arithmetic results, special
// divide cases, busy-time input masking, MTHI/MTLO and reset abort.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wd;
   logic        hilo_sel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] hilo_mux_out;

   int tests = 0;
   int fails = 0;

   hilo_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .we_hi(we_hi), .we_lo(we_lo), .wd(wd), .hilo_sel(hilo_sel),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .hilo_mux_out(hilo_mux_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, scramble operands after acceptance, wait for done.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cnt);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'(($urandom));
      busy_cnt = busy ? 1 : 0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (done) begin
            lat = n;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
      tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
   endtask

   task automatic test_multu();
      int lat, bc;
      do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
      tests++; if (lat !== 33) begin fails++; $display("FAIL multu_latency: got %0d want 33", lat); end
      tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
      tests++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
      tests++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", lo); end
      tick();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_mult();
      int lat, bc;
      do_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bc);
      tests++; if (lat !== 33) begin fails++; $display("FAIL mult_latency: got %0d want 33", lat); end
      hilo_sel = 1'b0; #1;
      tests++; if (hilo_mux_out !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_mux_lo: got %h want ffffffeb", hilo_mux_out); end
      hilo_sel = 1'b1; #1;
      tests++; if (hilo_mux_out !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_mux_hi: got %h want ffffffff", hilo_mux_out); end
      tests++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
      hilo_sel = 1'b0;
   endtask

   task automatic test_div();
      int lat, bc;
      do_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bc);
      tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
      tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
      do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bc);
      tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_minint_lo: got %h want 80000000", lo); end
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_minint_hi: got %h want 00000000", hi); end
      do_op(2'b11, 32'hFFFFFFFB, 32'd0, lat, bc);
      tests++; if (hi !== 32'hFFFFFFFB) begin fails++; $display("FAIL div_zero_signed_hi: got %h want fffffffb", hi); end
      tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_zero_signed_lo: got %h want ffffffff", lo); end
      do_op(2'b10, 32'd100, 32'd7, lat, bc);
      tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
      tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %h want 00000002", hi); end
      do_op(2'b10, 32'd100, 32'd0, lat, bc);
      tests++; if (lat !== 33) begin fails++; $display("FAIL divu_zero_latency: got %0d want 33", lat); end
      tests++; if (hi !== 32'h00000064) begin fails++; $display("FAIL divu_zero_hi: got %h want 00000064", hi); end
      tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo); end
   endtask

   // Relies on HI=0x64 left by the preceding DIVU 100/0.
   task automatic test_busy_ignore();
      int lat;
      op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
      tick();
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         if (n == 10) begin start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; end
         if (n == 12) begin we_hi = 1'b1; wd = 32'h1234; end
         tick();
         start = 1'b0; we_hi = 1'b0;
         if (n == 12) begin
            tests++; if (hi !== 32'h00000064) begin fails++; $display("FAIL busy_mthi_ignored: got %h want 00000064", hi); end
         end
         if (done) begin lat = n; break; end
      end
      tests++; if (lat !== 33) begin fails++; $display("FAIL busy_latency: got %0d want 33", lat); end
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL busy_hi: got %h want 00000000", hi); end
      tests++; if (lo !== 32'd30) begin fails++; $display("FAIL busy_lo: got %h want 0000001e", lo); end
   endtask

   task automatic test_mthi_mtlo();
      we_hi = 1'b1; we_lo = 1'b1; wd = 32'hA5A5A5A5;
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      tests++; if (hi !== 32'hA5A5A5A5) begin fails++; $display("FAIL mt_hi: got %h want a5a5a5a5", hi); end
      tests++; if (lo !== 32'hA5A5A5A5) begin fails++; $display("FAIL mt_lo: got %h want a5a5a5a5", lo); end
   endtask

   task automatic test_start_priority();
      int lat;
      op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
      we_hi = 1'b1; we_lo = 1'b1; wd = 32'hDEADBEEF;
      tick();
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      tests++; if (hi !== 32'hA5A5A5A5) begin fails++; $display("FAIL prio_hi: got %h want a5a5a5a5", hi); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL prio_busy: got %b want 1", busy); end
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (done) begin lat = n; break; end
      end
      tests++; if (lat !== 33) begin fails++; $display("FAIL prio_latency: got %0d want 33", lat); end
      tests++; if (lo !== 32'd6) begin fails++; $display("FAIL prio_lo: got %h want 00000006", lo); end
   endtask

   task automatic test_reset_abort();
      int lat, bc, spurious;
      we_hi = 1'b1; we_lo = 1'b1; wd = 32'h11111111;
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 14; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", done); end
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL abort_hi: got %h want 0", hi); end
      tests++; if (lo !== 32'h0) begin fails++; $display("FAIL abort_lo: got %h want 0", lo); end
      spurious = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (done) spurious++;
      end
      tests++; if (spurious !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", spurious); end
      do_op(2'b00, 32'd2, 32'd3, lat, bc);
      tests++; if (lat !== 33) begin fails++; $display("FAIL abort_retry_latency: got %0d want 33", lat); end
      tests++; if (lo !== 32'd6) begin fails++; $display("FAIL abort_retry_lo: got %h want 00000006", lo); end
      tests++; if (hi !== 32'd0) begin fails++; $display("FAIL abort_retry_hi: got %h want 00000000", hi); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      we_hi = 1'b0; we_lo = 1'b0; wd = '0; hilo_sel = 1'b0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_busy_ignore();
      test_mthi_mtlo();
      test_start_priority();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
